// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the demux12_deser receive path.
//   DEF_WIDTH  : default word width per channel
//   MAX_WIDTH  : widest word the shift helper supports
//   CH1 / CH2  : channel index constants (S=0 -> CH1, S=1 -> CH2)
//   shift_in() : one-bit shift step, MSB-first or LSB-first
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int MAX_WIDTH = 16;

    localparam int CH1 = 0;
    localparam int CH2 = 1;

    // Shift one bit into the low 'width' bits of sh. Bits above 'width'
    // are forced to zero so callers can simply truncate the result.
    //   msb_first=1 : {sh[width-2:0], d}  (first bit ends up in the MSB)
    //   msb_first=0 : {d, sh[width-1:1]}  (first bit ends up in the LSB)
    function automatic logic [MAX_WIDTH-1:0] shift_in(
        input logic [MAX_WIDTH-1:0] sh,
        input logic                 d,
        input int unsigned          width,
        input logic                 msb_first
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] masked;
        logic [MAX_WIDTH-1:0] res;
        // For width == MAX_WIDTH the shift wraps to zero and the
        // subtraction yields all ones, which is the desired mask.
        mask   = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
        masked = sh & mask;
        if (msb_first) begin
            res = {masked[MAX_WIDTH-2:0], d};
        end else begin
            res = (masked >> 1) | (MAX_WIDTH'(d) << (width - 1));
        end
        return res & mask;
    endfunction

endpackage

// File: rtl/demux12_deser_lane.sv
// -----------------------------------------------------------------------------
// deser_lane
// One channel of the deserializer: shift register, bit counter, output
// holding register and valid/ready handshake.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   clr_i      : synchronous clear of the partial word (shift reg + counter)
//   acc_i      : a bit for this channel is accepted this cycle
//   d_i        : the serial bit
//   y_ready_i  : consumer takes y_o
//   y_o        : completed word
//   y_valid_o  : y_o holds an unconsumed word
//   last_o     : counter sits at WIDTH-1 (next accepted bit completes)
//   busy_o     : partial word pending (counter non-zero)
// -----------------------------------------------------------------------------
module deser_lane
    import demux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             acc_i,
    input  logic             d_i,
    input  logic             y_ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic             y_valid_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 valid_q, valid_d;
    logic [MAX_WIDTH-1:0] sh_full;
    logic [WIDTH-1:0]     sh_shift;

    assign sh_full  = shift_in(MAX_WIDTH'(sh_q), d_i, WIDTH, MSB_FIRST);
    assign sh_shift = sh_full[WIDTH-1:0];

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        valid_d = valid_q;

        // Consumption first; a completion on the same edge overrides it
        // below so back-to-back words see no bubble.
        if (valid_q && y_ready_i) begin
            valid_d = 1'b0;
        end

        if (clr_i) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (acc_i) begin
            sh_d = sh_shift;
            if (cnt_q == LAST) begin
                y_d     = sh_shift;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y_o       = y_q;
    assign y_valid_o = valid_q;
    assign last_o    = (cnt_q == LAST);
    assign busy_o    = (cnt_q != '0);

endmodule

// File: rtl/demux12_deser.sv
// -----------------------------------------------------------------------------
// demux12_deser
// Receive end of the 2:1 mux path: steers each serial bit to channel 1
// (S=0) or channel 2 (S=1), assembles WIDTH-bit words per channel and
// presents them on independent valid/ready ports.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   D, S, in_valid     : serial bit, channel select, qualifier
//   in_ready           : bit accepted this cycle (combinational)
//   sync               : synchronous clear of partial words, drops D
//   Y1/Y1_valid/Y1_ready : channel 1 word port
//   Y2/Y2_valid/Y2_ready : channel 2 word port
//   ovf                : sticky, sync arrived while a partial word pending
// -----------------------------------------------------------------------------
module demux12_deser
    import demux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             D,
    input  logic             S,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sync,
    output logic [WIDTH-1:0] Y1,
    output logic             Y1_valid,
    input  logic             Y1_ready,
    output logic [WIDTH-1:0] Y2,
    output logic             Y2_valid,
    input  logic             Y2_ready,
    output logic             ovf
);

    logic [1:0]            acc;
    logic [1:0]            y_ready;
    logic [1:0]            y_valid;
    logic [1:0]            last;
    logic [1:0]            busy;
    logic [1:0][WIDTH-1:0] lane_y;
    logic                  accept;
    logic                  ovf_q, ovf_d;

    assign y_ready[CH1] = Y1_ready;
    assign y_ready[CH2] = Y2_ready;

    // Only a bit that would complete a word into a still-occupied,
    // not-draining holding register is stalled; the other channel and
    // non-completing bits always pass.
    assign in_ready = !sync && !(last[S] && y_valid[S] && !y_ready[S]);
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign acc[gi] = accept && (S == 1'(gi));

            deser_lane #(
                .WIDTH     (WIDTH),
                .MSB_FIRST (MSB_FIRST)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr_i     (sync),
                .acc_i     (acc[gi]),
                .d_i       (D),
                .y_ready_i (y_ready[gi]),
                .y_o       (lane_y[gi]),
                .y_valid_o (y_valid[gi]),
                .last_o    (last[gi]),
                .busy_o    (busy[gi])
            );
        end
    endgenerate

    assign ovf_d = ovf_q || (sync && (busy != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Y1       = lane_y[CH1];
    assign Y1_valid = y_valid[CH1];
    assign Y2       = lane_y[CH2];
    assign Y2_valid = y_valid[CH2];
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_demux12_deser.sv
// -----------------------------------------------------------------------------
// tb_demux12_deser
// Directed, table-driven bench for demux12_deser (WIDTH=4). A second
// instance built LSB-first shares all inputs and is checked on channel 2.
// -----------------------------------------------------------------------------
module tb_demux12_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       D, S, in_valid, sync, Y1_ready, Y2_ready;
    logic       in_ready, Y1_valid, Y2_valid, ovf;
    logic [3:0] Y1, Y2;

    logic       l_in_ready, l_Y1_valid, l_Y2_valid, l_ovf;
    logic [3:0] l_Y1, l_Y2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux12_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .D(D), .S(S), .in_valid(in_valid),
        .in_ready(in_ready), .sync(sync),
        .Y1(Y1), .Y1_valid(Y1_valid), .Y1_ready(Y1_ready),
        .Y2(Y2), .Y2_valid(Y2_valid), .Y2_ready(Y2_ready), .ovf(ovf)
    );

    demux12_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .D(D), .S(S), .in_valid(in_valid),
        .in_ready(l_in_ready), .sync(sync),
        .Y1(l_Y1), .Y1_valid(l_Y1_valid), .Y1_ready(Y1_ready),
        .Y2(l_Y2), .Y2_valid(l_Y2_valid), .Y2_ready(Y2_ready), .ovf(l_ovf)
    );

    typedef struct {
        logic       iv, s, d, sy, r1, r2;   // stimulus
        logic       e_rdy;                  // in_ready before the edge
        logic [3:0] e_y1;                   // outputs after the edge
        logic       e_v1;
        logic [3:0] e_y2;
        logic       e_v2;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, s, d, sy, r1, r2, e_rdy,
                       input logic [3:0] e_y1, input logic e_v1,
                       input logic [3:0] e_y2, input logic e_v2,
                       input logic e_ovf);
        vec_t v;
        v.iv = iv; v.s = s; v.d = d; v.sy = sy; v.r1 = r1; v.r2 = r2;
        v.e_rdy = e_rdy; v.e_y1 = e_y1; v.e_v1 = e_v1;
        v.e_y2 = e_y2; v.e_v2 = e_v2; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    // Drive one bit on the negedge, check in_ready, take the posedge.
    task automatic send(input logic s, input logic d);
        @(negedge clk);
        in_valid = 1'b1; S = s; D = d; sync = 1'b0;
        #1;
        chk("send_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; D = 0; S = 0; in_valid = 0; sync = 0;
        Y1_ready = 0; Y2_ready = 0;

        //   iv s  d  sy r1 r2 rdy  y1     v1  y2     v2  ovf
        // sync with nothing pending: ovf stays 0, in_ready forced low
        add(0, 0, 0, 1, 1, 1, 0, 4'h0, 0, 4'h0, 0, 0);
        // Test 1: ch1 bits 1,0,1,1 -> 1011
        add(1, 0, 1, 0, 1, 1, 1, 4'h0, 0, 4'h0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 1, 4'h0, 0, 4'h0, 0, 0);
        add(1, 0, 1, 0, 1, 1, 1, 4'h0, 0, 4'h0, 0, 0);
        add(1, 0, 1, 0, 1, 1, 1, 4'hB, 1, 4'h0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 4'hB, 0, 4'h0, 0, 0);
        // Test 2: interleaved, D1=1,1,0,0 D2=0,1,0,1, outputs held
        add(1, 0, 1, 0, 0, 0, 1, 4'hB, 0, 4'h0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1, 4'hB, 0, 4'h0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 1, 4'hB, 0, 4'h0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1, 4'hB, 0, 4'h0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 4'hB, 0, 4'h0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1, 4'hB, 0, 4'h0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 4'hC, 1, 4'h0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1, 4'hC, 1, 4'h5, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 4'hC, 0, 4'h5, 0, 0);
        // Test 3: Y2_ready=0, word 1001 held, then second word 0110
        add(1, 1, 1, 0, 1, 0, 1, 4'hC, 0, 4'h5, 0, 0);
        add(1, 1, 0, 0, 1, 0, 1, 4'hC, 0, 4'h5, 0, 0);
        add(1, 1, 0, 0, 1, 0, 1, 4'hC, 0, 4'h5, 0, 0);
        add(1, 1, 1, 0, 1, 0, 1, 4'hC, 0, 4'h9, 1, 0);
        add(1, 1, 0, 0, 1, 0, 1, 4'hC, 0, 4'h9, 1, 0);
        add(1, 1, 1, 0, 1, 0, 1, 4'hC, 0, 4'h9, 1, 0);
        add(1, 1, 1, 0, 1, 0, 1, 4'hC, 0, 4'h9, 1, 0);
        add(1, 1, 0, 0, 1, 0, 0, 4'hC, 0, 4'h9, 1, 0);  // stalled
        add(1, 0, 1, 0, 1, 0, 1, 4'hC, 0, 4'h9, 1, 0);  // ch1 still flows
        add(1, 1, 0, 0, 1, 0, 0, 4'hC, 0, 4'h9, 1, 0);  // still stalled
        add(1, 1, 0, 0, 1, 1, 1, 4'hC, 0, 4'h6, 1, 0);  // release, no bubble
        add(0, 0, 0, 0, 1, 1, 1, 4'hC, 0, 4'h6, 0, 0);
        // Test 4: ch1 has 1 bit, add one more, sync drops bit, then 0110
        add(1, 0, 0, 0, 1, 1, 1, 4'hC, 0, 4'h6, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0, 4'hC, 0, 4'h6, 0, 1);
        add(1, 0, 0, 0, 0, 1, 1, 4'hC, 0, 4'h6, 0, 1);
        add(1, 0, 1, 0, 0, 1, 1, 4'hC, 0, 4'h6, 0, 1);
        add(1, 0, 1, 0, 0, 1, 1, 4'hC, 0, 4'h6, 0, 1);
        add(1, 0, 0, 0, 0, 1, 1, 4'h6, 1, 4'h6, 0, 1);
        // held while !ready; non-completing ch1 bit not stalled
        add(1, 0, 1, 0, 0, 1, 1, 4'h6, 1, 4'h6, 0, 1);

        // reset state
        #12;
        chk("rst_y1", int'(Y1), 0);
        chk("rst_v1", int'(Y1_valid), 0);
        chk("rst_y2", int'(Y2), 0);
        chk("rst_v2", int'(Y2_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = vecs[i].iv; S = vecs[i].s; D = vecs[i].d;
            sync = vecs[i].sy; Y1_ready = vecs[i].r1; Y2_ready = vecs[i].r2;
            #1;
            chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_y1", i), int'(Y1), int'(vecs[i].e_y1));
            chk($sformatf("v%0d_v1", i), int'(Y1_valid), int'(vecs[i].e_v1));
            chk($sformatf("v%0d_y2", i), int'(Y2), int'(vecs[i].e_y2));
            chk($sformatf("v%0d_v2", i), int'(Y2_valid), int'(vecs[i].e_v2));
            chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].e_ovf));
            $display("vec %0d: iv=%0b s=%0b d=%0b sync=%0b -> Y1=%h/%0b Y2=%h/%0b ovf=%0b",
                     i, vecs[i].iv, vecs[i].s, vecs[i].d, vecs[i].sy,
                     Y1, Y1_valid, Y2, Y2_valid, ovf);
        end

        // Async reset mid-word with Y1_valid=1 (ch1 holds one partial bit)
        @(negedge clk);
        in_valid = 1'b0; Y1_ready = 1'b0; Y2_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y1", int'(Y1), 0);
        chk("arst_v1", int'(Y1_valid), 0);
        chk("arst_y2", int'(Y2), 0);
        chk("arst_v2", int'(Y2_valid), 0);
        chk("arst_ovf", int'(ovf), 0);
        $display("async reset: Y1=%h/%0b Y2=%h/%0b ovf=%0b", Y1, Y1_valid, Y2, Y2_valid, ovf);
        @(negedge clk);
        rst_n = 1'b1;

        // Full word after reset: 1,1,1,0 -> 1110
        send(0, 1); send(0, 1); send(0, 1);
        chk("post_rst_v1_early", int'(Y1_valid), 0);
        send(0, 0);
        chk("post_rst_y1", int'(Y1), 4'hE);
        chk("post_rst_v1", int'(Y1_valid), 1);
        $display("post-reset word: Y1=%h valid=%0b", Y1, Y1_valid);

        // Channel 2 bits 1,0,0,0: LSB-first build gives 0001, MSB-first 1000
        send(1, 1); send(1, 0); send(1, 0); send(1, 0);
        chk("lsb_y2", int'(l_Y2), 4'h1);
        chk("lsb_v2", int'(l_Y2_valid), 1);
        chk("msb_y2", int'(Y2), 4'h8);
        $display("ch2 1,0,0,0: lsb Y2=%h msb Y2=%h", l_Y2, Y2);

        @(negedge clk);
        in_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
